// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - core-side and backing-memory bus bundle for dcache_ctrl
interface dcache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data-cache controller
// Optional hit/miss statistics counters built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  dcache_ctrl_if.slave     bus,
  output logic             hit,
  output logic             miss,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_RD, MEM_WR} state_t;
  state_t state, state_nxt;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];

  logic [INDEX_BITS-1:0] line_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  lookup_hit;

  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q, hit_d, miss_q, miss_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              line_wr, line_fill;

  assign line_idx   = req_addr[INDEX_BITS+1:2];
  assign req_tag    = req_addr[ADDR_W-1:INDEX_BITS+2];
  assign lookup_hit = valid[line_idx] && (tag_arr[line_idx] == req_tag);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cpu_req) state_nxt = LOOKUP;
      LOOKUP: begin
        if (req_we)          state_nxt = MEM_WR;
        else if (lookup_hit) state_nxt = IDLE;
        else                 state_nxt = MEM_RD;
      end
      MEM_RD:  if (bus.mem_ack) state_nxt = IDLE;
      MEM_WR:  if (bus.mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; memory-side fields hold while mem_req is up.
  always_comb begin
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    line_wr     = 1'b0;
    line_fill   = 1'b0;
    case (state)
      LOOKUP: begin
        hit_d  = lookup_hit;
        miss_d = !lookup_hit;
        if (!req_we && lookup_hit) begin
          ready_d = 1'b1;
          rdata_d = data_arr[line_idx];
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = req_we;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          line_wr     = req_we && lookup_hit;
        end
      end
      MEM_RD: begin
        if (bus.mem_ack) begin
          ready_d   = 1'b1;
          rdata_d   = bus.mem_rdata;
          mem_req_d = 1'b0;
          line_fill = 1'b1;
        end
      end
      MEM_WR: begin
        if (bus.mem_ack) begin
          ready_d   = 1'b1;
          mem_req_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cpu_req) begin
      req_we    <= bus.cpu_we;
      req_addr  <= bus.cpu_addr;
      req_wdata <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          valid <= '0;
    else if (line_fill) valid[line_idx] <= 1'b1;
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!reset && line_wr) data_arr[line_idx] <= req_wdata;
    if (!reset && line_fill) begin
      tag_arr[line_idx]  <= req_tag;
      data_arr[line_idx] <= bus.mem_rdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_d && !(&hit_cnt))   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_d && !(&miss_cnt)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign hit           = hit_q;
  assign miss          = miss_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard testbench for dcache_ctrl
module tb_dcache_ctrl;
  logic        clk;
  logic        reset;
  logic        hit, miss;
  logic [15:0] hit_count, miss_count;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  dcache_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dcache_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_BITS(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .hit        (hit),
    .miss       (miss),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  typedef struct { int req_cyc; int lat; logic [31:0] rdata; } rdy_t;
  typedef struct { int req_cyc; logic is_hit; } lk_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mt_t;

  rdy_t rdy_q[$];
  lk_t  lk_q[$];
  mt_t  mt_q[$];

  logic [31:0] mem_model [logic [31:0]];
  int          ack_delay;
  logic        hold_ack, force_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Backing memory: acks ack_delay cycles after it first sees mem_req.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (hold_ack) begin
        wait_cnt = 0;
        bus.mem_ack = force_ack;
        bus.mem_rdata = 32'hBAD0BAD0;
      end else if (bus.mem_req) begin
        if (wait_cnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
          if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 32'h0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a pulse or a new memory request.
  initial begin
    rdy_t        r;
    lk_t         l;
    mt_t         m;
    logic        prev_req;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;
    prev_req = 1'b0;
    prev_we = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.cpu_ready) begin
          if (rdy_q.size() == 0) check("unexpected_cpu_ready", 1, 0);
          else begin
            r = rdy_q.pop_front();
            check("ready_latency", cyc - r.req_cyc, r.lat);
            check("cpu_rdata", bus.cpu_rdata, r.rdata);
          end
        end
        if (hit || miss) begin
          check("hit_miss_exclusive", hit & miss, 0);
          if (lk_q.size() == 0) check("unexpected_lookup", 1, 0);
          else begin
            l = lk_q.pop_front();
            check("lookup_hit", hit, l.is_hit);
            check("lookup_latency", cyc - l.req_cyc, 2);
          end
        end
        if (bus.mem_req && !prev_req) begin
          if (mt_q.size() == 0) check("unexpected_mem_req", 1, 0);
          else begin
            m = mt_q.pop_front();
            check("mem_we", bus.mem_we, m.we);
            check("mem_addr", bus.mem_addr, m.addr);
            if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
          end
        end else if (bus.mem_req && prev_req) begin
          check("mem_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {prev_we, prev_addr, prev_wdata});
        end
      end
      prev_req   = bus.mem_req;
      prev_we    = bus.mem_we;
      prev_addr  = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
    end
  end

  // Called just after a negedge with the DUT idle; returns at the negedge of the cpu_ready cycle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_hit, input int lat, input logic [31:0] exp_rdata);
    rdy_t r;
    lk_t  l;
    mt_t  m;
    int   n;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wdata;
    r.req_cyc = cyc; r.lat = lat; r.rdata = exp_rdata;
    rdy_q.push_back(r);
    l.req_cyc = cyc; l.is_hit = exp_hit;
    lk_q.push_back(l);
    if (we || !exp_hit) begin
      m.we = we; m.addr = addr; m.wdata = wdata;
      mt_q.push_back(m);
    end
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'hFFFF_FFFC;
    bus.cpu_wdata = 32'hA5A5_A5A5;
    n = 0;
    while (!bus.cpu_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cpu_ready) check("ready_timeout", 0, 1);
  endtask

  initial begin
    int   n;
    int   exp_h1, exp_m1, exp_h2, exp_m2;
    lk_t  l;
    mt_t  m;
`ifdef DCACHE_STATS_EN
    exp_h1 = 1; exp_m1 = 1; exp_h2 = 1; exp_m2 = 2;
`else
    exp_h1 = 0; exp_m1 = 0; exp_h2 = 0; exp_m2 = 0;
`endif
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    hold_ack = 1'b0;
    force_ack = 1'b0;
    ack_delay = 3;
    mem_model[32'h40]  = 32'hDEADBEEF;
    mem_model[32'h440] = 32'hCAFE0440;
    mem_model[32'h200] = 32'h00000200;

    repeat (3) @(negedge clk);
    check("rst_cpu_ready", bus.cpu_ready, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_hit_miss", {hit, miss}, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    check("rst_counters", {hit_count, miss_count}, 0);
    reset = 1'b0;
    @(negedge clk);

    do_req(1'b0, 32'h40, 32'h0, 1'b0, 6, 32'hDEADBEEF);
    do_req(1'b0, 32'h40, 32'h0, 1'b1, 2, 32'hDEADBEEF);
    check("hit_count_1", hit_count, exp_h1);
    check("miss_count_1", miss_count, exp_m1);
    do_req(1'b1, 32'h40, 32'h12345678, 1'b1, 6, 32'hDEADBEEF);
    do_req(1'b0, 32'h40, 32'h0, 1'b1, 2, 32'h12345678);

    ack_delay = 0;
    do_req(1'b1, 32'h84, 32'h55AA55AA, 1'b0, 3, 32'h12345678);
    do_req(1'b0, 32'h84, 32'h0, 1'b0, 3, 32'h55AA55AA);

    ack_delay = 1;
    do_req(1'b0, 32'h440, 32'h0, 1'b0, 4, 32'hCAFE0440);
    do_req(1'b0, 32'h40, 32'h0, 1'b0, 4, 32'h12345678);
    do_req(1'b0, 32'h40, 32'h0, 1'b1, 2, 32'h12345678);

    // Reset while a read miss waits in MEM_RD, then a late ack.
    @(negedge clk);
    hold_ack = 1'b1;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h200;
    l.req_cyc = cyc; l.is_hit = 1'b0;
    lk_q.push_back(l);
    m.we = 1'b0; m.addr = 32'h200; m.wdata = '0;
    mt_q.push_back(m);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_mem_req_seen", bus.mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_mem_req_low", bus.mem_req, 0);
    reset = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    check("late_ack_no_ready", bus.cpu_ready, 0);
    check("late_ack_no_mem_req", bus.mem_req, 0);
    repeat (2) @(negedge clk);
    check("post_rst_no_ready", bus.cpu_ready, 0);
    check("post_rst_cpu_rdata", bus.cpu_rdata, 0);
    check("post_rst_counters", {hit_count, miss_count}, 0);
    hold_ack = 1'b0;
    ack_delay = 0;
    @(negedge clk);

    do_req(1'b0, 32'h40, 32'h0, 1'b0, 3, 32'h12345678);
    do_req(1'b0, 32'h84, 32'h0, 1'b0, 3, 32'h55AA55AA);
    do_req(1'b0, 32'h84, 32'h0, 1'b1, 2, 32'h55AA55AA);
    check("hit_count_2", hit_count, exp_h2);
    check("miss_count_2", miss_count, exp_m2);

    repeat (5) @(negedge clk);
    check("ready_queue_drained", rdy_q.size(), 0);
    check("lookup_queue_drained", lk_q.size(), 0);
    check("mem_queue_drained", mt_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Parametrised direct-mapped data-cache controller that sits between the single-cycle core's data path (ALU address, rs2 store data) and `data_memory`. It succeeds the fixed 16-entry cache, adding configurable address, data and index widths and a real miss path. Read misses stall the core and allocate the line, using a request/acknowledge handshake to backing memory. Stores are write-through with no write-allocate.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data word width
- `INDEX_BITS`, 4, index width; the cache has 2^INDEX_BITS lines of one word each
- `CNT_W`, 16, width of the statistics counters
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  core request, sampled only in IDLE
- `cpu_we`  in  1  1 = store, 0 = load; captured together with `cpu_req`
- `cpu_addr`  in  ADDR_W  byte address; bits [1:0] are ignored
- `cpu_wdata`  in  DATA_W  store data
- `cpu_ready`  out  1  registered one-cycle completion pulse
- `cpu_rdata`  out  DATA_W  registered load data; holds its value between loads
- `hit`, `miss`  out  1  registered one-cycle lookup-result pulses
- `mem_req`  out  1  backing-memory request, held until acknowledged
- `mem_we`  out  1  backing-memory write enable
- `mem_addr`  out  ADDR_W  backing-memory address
- `mem_wdata`  out  DATA_W  backing-memory write data
- `mem_ack`  in  1  memory acknowledge; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  DATA_W  memory read data
- `hit_count`, `miss_count`  out  CNT_W  statistics counters (see Configuration)

## Operation
- Address split: tag = `addr[ADDR_W-1:INDEX_BITS+2]`; index = `addr[INDEX_BITS+1:2]`.
- Per line the cache stores a valid bit, a tag and one data word.
- States are IDLE, LOOKUP, MEM_RD and MEM_WR.
- IDLE: when `cpu_req`=1, capture we/addr/wdata and go to LOOKUP.
- LOOKUP, read hit: pulse `hit`, load `cpu_rdata` from the line, pulse `cpu_ready`, go to IDLE.
- LOOKUP, read miss: pulse `miss`, drive `mem_req`=1, `mem_we`=0, `mem_addr`=captured address, go to MEM_RD.
- LOOKUP, write hit: pulse `hit`, write the line's data word, drive `mem_req`=1, `mem_we`=1 with the captured address and data, go to MEM_WR.
- LOOKUP, write miss: pulse `miss`, leave the cache array unchanged, issue the same memory write, go to MEM_WR.
- MEM_RD, on `mem_ack`: write tag/data/valid into the line, set `cpu_rdata`=`mem_rdata`, pulse `cpu_ready`, drop `mem_req`, go to IDLE.
- MEM_WR, on `mem_ack`: pulse `cpu_ready`, drop `mem_req`, go to IDLE.
- `mem_ack` is ignored whenever the block is not in MEM_RD or MEM_WR.
- While in LOOKUP, MEM_RD or MEM_WR, the core inputs are ignored and no new request is captured.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req`=1.

## Timing
- Reset values: state IDLE, all valid bits 0, all outputs 0, counters 0. Tag and data arrays need no reset.
- Reset mid-operation:
  - abandons any outstanding memory transaction;
  - `mem_req` is 0 in the cycle after the reset edge;
  - a late `mem_ack` has no effect;
  - no `cpu_ready` is issued for the abandoned request.
- If `cpu_req` is accepted at edge of cycle N, then cycle N+1 is LOOKUP.
- Read hit: `hit` and `cpu_ready` are high in cycle N+2, with `cpu_rdata` valid in N+2.
- Miss or write:
  - `hit`/`miss` and `mem_req` are first high in cycle N+2;
  - if `mem_ack` is high in cycle M (M ≥ N+2), then `mem_req` is low and `cpu_ready` high in M+1;
  - for a read, `cpu_rdata` is valid in M+1.
- Back-to-back: in the `cpu_ready` cycle the block is already in IDLE and may accept the next request.
- Read-after-fill: a read fill is visible to a lookup in the very next request.
- Write-hit data is visible to the next lookup, before the memory ack.
- The minimum transaction length is one MEM cycle (ack in N+2 gives ready in N+3).

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments on every `hit` pulse and `miss_count` on every `miss` pulse;
  - both saturate at all-ones and clear on reset.
- `DCACHE_STATS_EN` undefined: no counter logic is built; `hit_count` and `miss_count` are tied to 0.

## Test plan
- Reset, then load 0x40 with memory returning 0xDEADBEEF and ack 3 cycles after `mem_req` → `miss` pulses; `mem_addr`=0x40, `mem_we`=0; `cpu_ready` and `cpu_rdata`=0xDEADBEEF one cycle after ack.
- Load 0x40 again → `hit` and `cpu_ready` two cycles after the request, `cpu_rdata`=0xDEADBEEF, no `mem_req`; with the macro, `hit_count`=1 and `miss_count`=1.
- Store 0x12345678 to 0x40 (hit), then load 0x40 → `mem_req`/`mem_we`=1 with `mem_wdata`=0x12345678; the load hits and returns 0x12345678.
- Store to 0x80 (miss), then load 0x80 → `miss` on the store and no allocation; the load also misses and issues a memory read.
- Conflict at INDEX_BITS=4: load 0x40 then load 0x440 (same index, new tag) → both miss; a following load of 0x40 misses again.
- Assert `reset` while in MEM_RD, then raise `mem_ack` → `mem_req`=0 the next cycle; no `cpu_ready`; all lines invalid; counters 0.
